// File: rtl/wbdbg_serializer_pkg.sv
// Shared constants for the debug-transaction serializer and its host-side decoder.
// Frame layout: SYNC, NBYTES data bytes MSB-first, optional XOR checksum.
package wbdbg_serializer_pkg;

    localparam int         BUSBITS_DEF = 72;
    localparam int         DEPTH_DEF   = 8;
    localparam logic [7:0] SYNC_DEF    = 8'hA5;

    function automatic int nbytes(input int busbits);
        return busbits / 8;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SOF  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } ser_state_e;

    // Byte offsets within a frame, as seen by the host decoder
    localparam int FRM_SYNC_OFS = 0;
    localparam int FRM_DATA_OFS = 1;

    function automatic int frm_csum_ofs(input int busbits);
        return FRM_DATA_OFS + nbytes(busbits);
    endfunction

endpackage

// File: rtl/wbdbg_serializer_fsfifo.sv
// First-word-fall-through transaction buffer (the serializer's fsfifo).
// Writes to a full buffer and reads from an empty one are ignored.
module wbdbg_serializer_fsfifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             wr_ok, rd_ok;

    assign o_empty = (cnt_q == '0);
    assign o_full  = (cnt_q == (AW+1)'(DEPTH));
    assign wr_ok   = i_wr && !o_full;
    assign rd_ok   = i_rd && !o_empty;
    assign o_data  = mem_q[rptr_q];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_ok) wptr_q <= wptr_q + AW'(1);
            if (rd_ok) rptr_q <= rptr_q + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) mem_q[wptr_q] <= i_data;
    end

endmodule

// File: rtl/wbdbg_serializer.sv
// Buffers debug-monitor transactions and streams each as a SYNC-framed byte sequence.
// Define WBDBG_SER_CSUM_EN to append an XOR checksum byte to every frame.
module wbdbg_serializer
    import wbdbg_serializer_pkg::*;
#(
    parameter int         BUSBITS = BUSBITS_DEF,
    parameter int         DEPTH   = DEPTH_DEF,
    parameter logic [7:0] SYNC    = SYNC_DEF
) (
    input  logic               i_wb_clk,
    input  logic               i_wb_rst,
    input  logic               i_dbg_rst,
    input  logic               i_dbg_stb,
    input  logic [BUSBITS-1:0] i_dbg_txn,
    output logic               o_byte_valid,
    output logic [7:0]         o_byte,
    input  logic               i_byte_ready,
    output logic               o_busy,
    output logic [7:0]         o_drop_cnt
);

    localparam int             NBYTES = nbytes(BUSBITS);
    localparam int             BW     = $clog2(NBYTES);
    localparam logic [BW-1:0]  LAST   = BW'(NBYTES - 1);

    ser_state_e         state_q;
    logic [BUSBITS-1:0] txn_q;
    logic [BW-1:0]      bidx_q;
    logic [7:0]         byte_q;
    logic               valid_q;
    logic [7:0]         drop_q, drop_d;
`ifdef WBDBG_SER_CSUM_EN
    logic [7:0]         csum_q;
`endif

    logic               fifo_rst, empty, full, pop, xfer;
    logic [BUSBITS-1:0] head;

    assign fifo_rst = i_wb_rst || i_dbg_rst;
    assign pop      = (state_q == ST_IDLE) && !empty;
    assign xfer     = valid_q && i_byte_ready;

    wbdbg_serializer_fsfifo #(.WIDTH(BUSBITS), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_wb_clk),
        .i_rst   (fifo_rst),
        .i_wr    (i_dbg_stb),
        .i_data  (i_dbg_txn),
        .i_rd    (pop),
        .o_data  (head),
        .o_empty (empty),
        .o_full  (full)
    );

    // full is the pre-edge value, so a strobe while full drops even if a pop coincides
    always_comb begin
        drop_d = drop_q;
        if (i_dbg_stb && full && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            drop_q <= '0;
        end else if (i_dbg_rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_q <= ST_IDLE;
            txn_q   <= '0;
            bidx_q  <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
`ifdef WBDBG_SER_CSUM_EN
            csum_q  <= '0;
`endif
        end else if (i_dbg_rst) begin
            state_q <= ST_IDLE;
            txn_q   <= '0;
            bidx_q  <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
`ifdef WBDBG_SER_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        txn_q   <= head;
                        bidx_q  <= '0;
                        byte_q  <= SYNC;
                        valid_q <= 1'b1;
`ifdef WBDBG_SER_CSUM_EN
                        csum_q  <= '0;
`endif
                        state_q <= ST_SOF;
                    end
                end
                ST_SOF: begin
                    if (xfer) begin
                        byte_q  <= txn_q[BUSBITS-1 -: 8];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        txn_q  <= txn_q << 8;
                        bidx_q <= bidx_q + BW'(1);
                        // byte_q is the byte just accepted; the next one sits right below it
                        byte_q <= txn_q[BUSBITS-9 -: 8];
`ifdef WBDBG_SER_CSUM_EN
                        csum_q <= csum_q ^ byte_q;
                        if (bidx_q == LAST) begin
                            byte_q  <= csum_q ^ byte_q;
                            state_q <= ST_CSUM;
                        end
`else
                        if (bidx_q == LAST) begin
                            valid_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end
`endif
                    end
                end
`ifdef WBDBG_SER_CSUM_EN
                ST_CSUM: begin
                    if (xfer) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_byte_valid = valid_q;
    assign o_byte       = byte_q;
    assign o_drop_cnt   = drop_q;
    assign o_busy       = !empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_wbdbg_serializer.sv
// Directed bench for wbdbg_serializer: framing, stalls, overflow, drop saturation, resets.
// Build with WBDBG_SER_CSUM_EN to also expect the trailing checksum byte.
module tb_wbdbg_serializer;

`ifdef WBDBG_SER_CSUM_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    localparam logic [71:0] T1A  = 72'h01_2345_6789_ABCD_EFF0;
    localparam logic [71:0] T1B  = 72'hFF_0080_4020_1008_0402;
    localparam logic [71:0] T1C  = 72'h3C_C35A_A500_FF11_EE77;
    localparam logic [71:0] HOLD = 72'h99_8877_6655_4433_2211;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dbg = 1'b0;
    logic        stb = 1'b0;
    logic [71:0] txn = '0;
    logic        rdy = 1'b0;
    logic        o_byte_valid;
    logic [7:0]  o_byte;
    logic        o_busy;
    logic [7:0]  o_drop_cnt;

    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  rx[$];

    always #5 clk = ~clk;

    wbdbg_serializer dut (
        .i_wb_clk     (clk),
        .i_wb_rst     (rst),
        .i_dbg_rst    (dbg),
        .i_dbg_stb    (stb),
        .i_dbg_txn    (txn),
        .o_byte_valid (o_byte_valid),
        .o_byte       (o_byte),
        .i_byte_ready (rdy),
        .o_busy       (o_busy),
        .o_drop_cnt   (o_drop_cnt)
    );

    // Inputs change only at posedge+2, so a valid&&ready seen here is the transfer at the next edge
    always @(negedge clk) begin
        if (o_byte_valid && rdy && !rst && !dbg) rx.push_back(o_byte);
    end

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic strobe(input logic [71:0] t);
        stb = 1'b1;
        txn = t;
        tick();
        stb = 1'b0;
    endtask

    task automatic pulse_dbg();
        dbg = 1'b1;
        tick();
        dbg = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [71:0] t);
        logic [7:0] x;
        for (int c = 0; c < 200 && rx.size() < FL; c++) tick();
        chk({tag, "_len"}, 72'(rx.size() >= FL), 72'd1);
        if (rx.size() < FL) return;
        chk({tag, "_sync"}, 72'(rx.pop_front()), 72'hA5);
        x = 8'h00;
        for (int i = 0; i < 9; i++) begin
            x ^= t[71-8*i -: 8];
            chk($sformatf("%s_b%0d", tag, i), 72'(rx.pop_front()), 72'(t[71-8*i -: 8]));
        end
`ifdef WBDBG_SER_CSUM_EN
        chk({tag, "_csum"}, 72'(rx.pop_front()), 72'(x));
`endif
    endtask

    function automatic logic [71:0] t3v(input int i);
        return {8'(8'h30 + i), 56'(i) * 56'h01_0101_0101_0101, 8'(8'hC0 + i)};
    endfunction

    logic       pv, pr;
    logic [7:0] pb;
    logic [7:0] exp_t1 [10];

    initial begin
        // Reset state
        tick();
        chk("rst_valid", 72'(o_byte_valid), 72'd0);
        chk("rst_byte",  72'(o_byte),       72'd0);
        chk("rst_busy",  72'(o_busy),       72'd0);
        chk("rst_drop",  72'(o_drop_cnt),   72'd0);
        rst = 1'b0;
        tick();

        // T1: latency and a single frame with ready held high
        rdy = 1'b1;
        strobe(T1A);
        chk("lat_n1_valid", 72'(o_byte_valid), 72'd0);
        chk("lat_n1_busy",  72'(o_busy),       72'd1);
        tick();
        chk("lat_n2_valid", 72'(o_byte_valid), 72'd1);
        chk("lat_n2_sync",  72'(o_byte),       72'hA5);
        exp_t1 = '{8'hA5, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'hF0};
        for (int c = 0; c < 40 && rx.size() < FL; c++) tick();
        for (int i = 0; i < 10; i++)
            chk($sformatf("t1_lit%0d", i), 72'(rx[i]), 72'(exp_t1[i]));
        check_frame("t1", T1A);
        tick();
        tick();
        chk("t1_idle_busy", 72'(o_busy), 72'd0);

        // Two back-to-back frames
        strobe(T1B);
        strobe(T1C);
        check_frame("b2b_0", T1B);
        check_frame("b2b_1", T1C);

        // T2: ready toggles every cycle; held bytes must not change
        rdy = 1'b0;
        strobe(T1A);
        for (int c = 0; c < 80 && rx.size() < FL; c++) begin
            rdy = c[0];
            pv  = o_byte_valid;
            pr  = rdy;
            pb  = o_byte;
            tick();
            if (pv && !pr) begin
                chk("t2_hold_valid", 72'(o_byte_valid), 72'd1);
                chk("t2_hold_byte",  72'(o_byte),       72'(pb));
            end
        end
        check_frame("t2", T1A);
        rdy = 1'b1;
        tick();

        // T3: the FSM holds HOLD stalled, so the 10 strobes see an empty 8-deep buffer
        rdy = 1'b0;
        strobe(HOLD);
        tick();
        for (int i = 0; i < 10; i++) strobe(t3v(i));
        chk("t3_drop", 72'(o_drop_cnt), 72'd2);
        chk("t3_busy", 72'(o_busy),     72'd1);
        rdy = 1'b1;
        check_frame("t3_hold", HOLD);
        for (int i = 0; i < 8; i++) check_frame($sformatf("t3_f%0d", i), t3v(i));
        tick();
        tick();
        chk("t3_done_busy", 72'(o_busy),     72'd0);
        chk("t3_done_drop", 72'(o_drop_cnt), 72'd2);
        pulse_dbg();
        rx.delete();
        chk("t3_clr_drop", 72'(o_drop_cnt), 72'd0);

        // T4: first strobe goes to the FSM, next 8 fill the buffer, the rest drop
        rdy = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            strobe(72'(k) * 72'h1357);
            if (k == 10)  chk("t4_drop10",  72'(o_drop_cnt), 72'd1);
            if (k == 100) chk("t4_drop100", 72'(o_drop_cnt), 72'd91);
            if (k == 263) chk("t4_drop263", 72'(o_drop_cnt), 72'd254);
            if (k == 264) chk("t4_drop264", 72'(o_drop_cnt), 72'd255);
            if (k == 300) chk("t4_drop300", 72'(o_drop_cnt), 72'd255);
        end

        // T5: synchronous debug reset in the middle of a frame
        rdy = 1'b1;
        for (int c = 0; c < 40 && rx.size() < 4; c++) tick();
        chk("t5_pre", 72'(rx.size() >= 4), 72'd1);
        pulse_dbg();
        chk("t5_valid", 72'(o_byte_valid), 72'd0);
        chk("t5_byte",  72'(o_byte),       72'd0);
        chk("t5_busy",  72'(o_busy),       72'd0);
        chk("t5_drop",  72'(o_drop_cnt),   72'd0);
        rx.delete();
        repeat (15) tick();
        chk("t5_quiet", 72'(rx.size()), 72'd0);
        strobe(T1B);
        check_frame("t5", T1B);

        // T6: asynchronous reset asserted mid-cycle
        strobe(T1C);
        for (int c = 0; c < 40 && rx.size() < 3; c++) tick();
        chk("t6_pre", 72'(rx.size() >= 3), 72'd1);
        rst = 1'b1;
        #1;
        chk("t6_valid", 72'(o_byte_valid), 72'd0);
        chk("t6_byte",  72'(o_byte),       72'd0);
        chk("t6_busy",  72'(o_busy),       72'd0);
        #1;
        rst = 1'b0;
        tick();
        rx.delete();
        repeat (12) tick();
        chk("t6_quiet", 72'(rx.size()), 72'd0);
        strobe(T1A);
        check_frame("t6", T1A);
        chk("t6_drop", 72'(o_drop_cnt), 72'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
